serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_subtractor_fs.sv | 13 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_pkg;

  localparam int SERIAL_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must hold the value N after the last shift, so it needs room for N+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: difference and borrow-out for x - y - bin.
module fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^N, bout = (a < b).
// Operands are shifted LSB first through a one-bit subtractor over N cycles.
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int N = SERIAL_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int CW = cnt_width(N);

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           borrow_q, borrow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           d_s;
  logic           nb_s;

  fs u_fs (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (borrow_q),
    .d   (d_s),
    .bo  (nb_s)
  );

  // State register; busy/done are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath registers: A doubles as the result register once shifting completes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q      <= {N{1'b0}};
      b_q      <= {N{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update; registers hold outside load and shift.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SHIFT;
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          cnt_d    = {CW{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d      = {d_s, a_q[N-1:1]};
        b_d      = {1'b0, b_q[N-1:1]};
        borrow_d = nb_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_SHIFT: busy_d = 1'b1;
      ST_DONE:  done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = a_q;
  assign bout = borrow_q;

endmodule
